// File: rtl/cva6v_trace_ctrl_pkg.sv
// cva6v_trace_ctrl_pkg: shared state encoding and default counter width for the trace controller
// Contents: CntWDefault (default retired-instruction counter width), state_e (3-bit FSM encoding).
package cva6v_trace_ctrl_pkg;
    localparam int CntWDefault = 32;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPEN   = 3'd1,
        ST_TRACE  = 3'd2,
        ST_ROTATE = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;
endpackage

// File: rtl/cva6v_trace_ctrl_if.sv
// cva6v_trace_ctrl_if: control/status bundle between the trace controller and its environment
// Signals: start_i, stop_i, rotate_limit_i, commit_valid_i, end_of_test_i (environment to controller);
// enable_o, new_file_o, file_idx_o, instr_cnt_o, state_o, done_o (controller to environment).
// Modports: master = environment side, slave = controller side.
interface cva6v_trace_ctrl_if import cva6v_trace_ctrl_pkg::*; #(
    parameter int NrCommitPorts = 2,
    parameter int CntW = CntWDefault
);
    logic                     start_i;
    logic                     stop_i;
    logic [CntW-1:0]          rotate_limit_i;
    logic [NrCommitPorts-1:0] commit_valid_i;
    logic [31:0]              end_of_test_i;
    logic                     enable_o;
    logic                     new_file_o;
    logic [15:0]              file_idx_o;
    logic [CntW-1:0]          instr_cnt_o;
    logic [2:0]               state_o;
    logic                     done_o;
    modport master (
        output start_i, stop_i, rotate_limit_i, commit_valid_i, end_of_test_i,
        input  enable_o, new_file_o, file_idx_o, instr_cnt_o, state_o, done_o
    );
    modport slave (
        input  start_i, stop_i, rotate_limit_i, commit_valid_i, end_of_test_i,
        output enable_o, new_file_o, file_idx_o, instr_cnt_o, state_o, done_o
    );
endinterface

// File: rtl/cva6v_trace_commit_cnt.sv
// cva6v_trace_commit_cnt: popcount of retire-valid bits feeding a saturating commit counter
// Ports: clk_i, rst_i (sync, active-high); clear (zero the count), load (count := this cycle's popcount),
// en (count += popcount, saturating); commit_valid (per-port retire-valid);
// cnt (current count); sum (unsaturated cnt + popcount, one bit wider, for threshold compares).
module cva6v_trace_commit_cnt import cva6v_trace_ctrl_pkg::*; #(
    parameter int NrCommitPorts = 2,
    parameter int CntW = CntWDefault
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     en,
    input  logic [NrCommitPorts-1:0] commit_valid,
    output logic [CntW-1:0]          cnt,
    output logic [CntW:0]            sum
);
    localparam int PopW = $clog2(NrCommitPorts + 1);
    logic [PopW-1:0] pop;
    always_comb begin
        pop = '0;
        for (int i = 0; i < NrCommitPorts; i++) pop = pop + PopW'(commit_valid[i]);
        sum = {1'b0, cnt} + (CntW + 1)'(pop);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) cnt <= '0;
        else if (load) cnt <= CntW'(pop);
        else if (en) cnt <= sum[CntW] ? '1 : sum[CntW-1:0];
    end
endmodule

// File: rtl/cva6v_trace_ctrl.sv
// cva6v_trace_ctrl: trace session FSM gating the tracer, rotating trace files and counting commits
// Ports: clk_i, rst_i (sync, active-high); bus (cva6v_trace_ctrl_if.slave) carrying start/stop requests,
// rotate limit, commit valids, end-of-test word and the enable/new_file/file_idx/instr_cnt/state/done status.
// Build option: define CVA6V_TRACE_CTRL_ROTATE_EN to enable file rotation after rotate_limit_i commits.
module cva6v_trace_ctrl import cva6v_trace_ctrl_pkg::*; #(
    parameter int NrCommitPorts = 2,
    parameter int CntW = CntWDefault,
    parameter int DrainCycles = 4
) (
    input logic clk_i,
    input logic rst_i,
    cva6v_trace_ctrl_if.slave bus
);
    localparam int DrainW = DrainCycles > 1 ? $clog2(DrainCycles) : 1;
    state_e st;
    logic enable, new_file, done, halt, rot_hit;
    logic [15:0] file_idx;
    logic [DrainW-1:0] drain;
    logic [CntW-1:0] cnt;
    logic [CntW:0] sum;
    assign halt = bus.stop_i || |bus.end_of_test_i;
`ifdef CVA6V_TRACE_CTRL_ROTATE_EN
    assign rot_hit = |bus.rotate_limit_i && sum >= {1'b0, bus.rotate_limit_i};
`else
    logic unused_limit;
    assign unused_limit = ^bus.rotate_limit_i;
    assign rot_hit = 1'b0;
`endif
    cva6v_trace_commit_cnt #(.NrCommitPorts(NrCommitPorts), .CntW(CntW)) u_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clear(st == ST_OPEN),
        .load(st == ST_ROTATE),
        .en(st == ST_TRACE || st == ST_DRAIN),
        .commit_valid(bus.commit_valid_i),
        .cnt(cnt),
        .sum(sum)
    );
    // Outputs are registered alongside the state, so new_file and the file index step land in the OPEN/ROTATE cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st       <= ST_IDLE;
            enable   <= 1'b0;
            new_file <= 1'b0;
            done     <= 1'b0;
            file_idx <= 16'hFFFF;
            drain    <= '0;
        end else begin
            new_file <= 1'b0;
            case (st)
                ST_IDLE, ST_DONE: begin
                    if (bus.start_i && !bus.stop_i) begin
                        st       <= ST_OPEN;
                        enable   <= 1'b1;
                        new_file <= 1'b1;
                        done     <= 1'b0;
                        file_idx <= file_idx + 16'd1;
                    end
                end
                ST_OPEN, ST_TRACE, ST_ROTATE: begin
                    if (halt) begin
                        st    <= ST_DRAIN;
                        drain <= '0;
                    end else if (st == ST_TRACE && rot_hit) begin
                        st       <= ST_ROTATE;
                        new_file <= 1'b1;
                        file_idx <= file_idx + 16'd1;
                    end else begin
                        st <= ST_TRACE;
                    end
                end
                ST_DRAIN: begin
                    if (drain == DrainW'(DrainCycles - 1)) begin
                        st     <= ST_DONE;
                        enable <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        drain <= drain + 1'b1;
                    end
                end
                default: begin
                    st     <= ST_IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end
    assign bus.enable_o    = enable;
    assign bus.new_file_o  = new_file;
    assign bus.done_o      = done;
    assign bus.file_idx_o  = file_idx;
    assign bus.instr_cnt_o = cnt;
    assign bus.state_o     = st;
endmodule

// File: tb/tb_cva6v_trace_ctrl.sv
// tb_cva6v_trace_ctrl: scoreboard bench for the trace controller (rotation cases when CVA6V_TRACE_CTRL_ROTATE_EN is set)
module tb_cva6v_trace_ctrl;
    import cva6v_trace_ctrl_pkg::*;
    typedef struct {
        int          cyc;
        string       name;
        logic [2:0]  st;
        logic        en;
        logic        nf;
        logic        dn;
        logic [15:0] idx;
        logic [31:0] cnt;
    } snap_t;
    logic clk, rst;
    int cyc = 0;
    int checks = 0;
    int passes = 0;
    bit ending = 0;
    bit mon_done = 0;
    snap_t sb[$];
    logic [15:0] pq[$];
    snap_t e;
    logic [15:0] pidx;
    cva6v_trace_ctrl_if #(.NrCommitPorts(2), .CntW(32)) bus ();
    cva6v_trace_ctrl #(.NrCommitPorts(2), .CntW(32), .DrainCycles(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Monitor: pops expected snapshots for this cycle, and matches every new_file pulse against the pulse queue.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if ({bus.state_o, bus.enable_o, bus.new_file_o, bus.done_o, bus.file_idx_o, bus.instr_cnt_o} !==
                {e.st, e.en, e.nf, e.dn, e.idx, e.cnt})
                $display("FAIL %s: got st=%0d en=%b nf=%b done=%b idx=%h cnt=%0d, want st=%0d en=%b nf=%b done=%b idx=%h cnt=%0d",
                         e.name, bus.state_o, bus.enable_o, bus.new_file_o, bus.done_o, bus.file_idx_o, bus.instr_cnt_o,
                         e.st, e.en, e.nf, e.dn, e.idx, e.cnt);
            else passes++;
        end
        if (bus.new_file_o === 1'b1) begin
            checks++;
            if (pq.size() == 0) begin
                $display("FAIL pulse: unexpected new_file_o at cycle %0d, file_idx=%h, want no pulse", cyc, bus.file_idx_o);
            end else begin
                pidx = pq.pop_front();
                if (bus.file_idx_o !== pidx) $display("FAIL pulse_idx: got file_idx=%h, want %h", bus.file_idx_o, pidx);
                else passes++;
            end
        end
        if (ending && !mon_done) begin
            checks++;
            if (sb.size() != 0 || pq.size() != 0)
                $display("FAIL drained: got %0d snapshots and %0d pulses outstanding, want 0 and 0", sb.size(), pq.size());
            else passes++;
            mon_done = 1'b1;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic step(input string name, input logic [2:0] st, input logic en, input logic nf, input logic dn,
                        input logic [15:0] idx, input logic [31:0] cnt);
        snap_t s;
        tick();
        s.cyc = cyc; s.name = name; s.st = st; s.en = en; s.nf = nf; s.dn = dn; s.idx = idx; s.cnt = cnt;
        sb.push_back(s);
    endtask
    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.stop_i = 1'b0;
        bus.rotate_limit_i = '0;
        bus.commit_valid_i = '0;
        bus.end_of_test_i = '0;
        step("reset0", ST_IDLE, 0, 0, 0, 16'hFFFF, 0);
        step("reset1", ST_IDLE, 0, 0, 0, 16'hFFFF, 0);
        rst = 1'b0;
        bus.stop_i = 1'b1;
        step("stop_in_idle", ST_IDLE, 0, 0, 0, 16'hFFFF, 0);
        bus.stop_i = 1'b0;
        bus.start_i = 1'b1;
        pq.push_back(16'd0);
        step("open0", ST_OPEN, 1, 1, 0, 16'd0, 0);
        bus.start_i = 1'b0;
        step("trace0", ST_TRACE, 1, 0, 0, 16'd0, 0);
        bus.commit_valid_i = 2'b11;
        for (int i = 1; i <= 10; i++) step($sformatf("cnt11_%0d", i), ST_TRACE, 1, 0, 0, 16'd0, 32'(2 * i));
        bus.commit_valid_i = 2'b00;
        bus.stop_i = 1'b1;
        step("stop_drain", ST_DRAIN, 1, 0, 0, 16'd0, 20);
        bus.stop_i = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("drain_%0d", i), ST_DRAIN, 1, 0, 0, 16'd0, 20);
        step("done0", ST_DONE, 0, 0, 1, 16'd0, 20);
        bus.start_i = 1'b1;
        bus.stop_i = 1'b1;
        step("start_stop_done", ST_DONE, 0, 0, 1, 16'd0, 20);
        bus.stop_i = 1'b0;
        pq.push_back(16'd1);
        step("open1", ST_OPEN, 1, 1, 0, 16'd1, 20);
        bus.start_i = 1'b0;
        step("trace1", ST_TRACE, 1, 0, 0, 16'd1, 0);
        bus.commit_valid_i = 2'b01;
        step("eot_pre1", ST_TRACE, 1, 0, 0, 16'd1, 1);
        step("eot_pre2", ST_TRACE, 1, 0, 0, 16'd1, 2);
        bus.end_of_test_i = 32'h1;
        step("eot_drain", ST_DRAIN, 1, 0, 0, 16'd1, 3);
        bus.end_of_test_i = 32'h0;
        bus.commit_valid_i = 2'b11;
        step("eot_d1", ST_DRAIN, 1, 0, 0, 16'd1, 5);
        bus.commit_valid_i = 2'b01;
        step("eot_d2", ST_DRAIN, 1, 0, 0, 16'd1, 6);
        bus.commit_valid_i = 2'b00;
        step("eot_d3", ST_DRAIN, 1, 0, 0, 16'd1, 6);
        step("eot_done", ST_DONE, 0, 0, 1, 16'd1, 6);
        bus.start_i = 1'b1;
        pq.push_back(16'd2);
        step("open2", ST_OPEN, 1, 1, 0, 16'd2, 6);
        bus.start_i = 1'b0;
        step("trace2", ST_TRACE, 1, 0, 0, 16'd2, 0);
        bus.commit_valid_i = 2'b01;
        for (int i = 1; i <= 7; i++) begin
            bus.start_i = (i == 4);
            step($sformatf("rst_pre%0d", i), ST_TRACE, 1, 0, 0, 16'd2, 32'(i));
        end
        bus.start_i = 1'b0;
        bus.commit_valid_i = 2'b00;
        rst = 1'b1;
        step("mid_reset", ST_IDLE, 0, 0, 0, 16'hFFFF, 0);
        rst = 1'b0;
        step("post_reset", ST_IDLE, 0, 0, 0, 16'hFFFF, 0);
`ifdef CVA6V_TRACE_CTRL_ROTATE_EN
        bus.rotate_limit_i = 32'd5;
        bus.start_i = 1'b1;
        pq.push_back(16'd0);
        step("r_open", ST_OPEN, 1, 1, 0, 16'd0, 0);
        bus.start_i = 1'b0;
        step("r_trace", ST_TRACE, 1, 0, 0, 16'd0, 0);
        bus.commit_valid_i = 2'b01;
        for (int i = 1; i <= 4; i++) step($sformatf("r_cnt%0d", i), ST_TRACE, 1, 0, 0, 16'd0, 32'(i));
        pq.push_back(16'd1);
        step("r_rotate", ST_ROTATE, 1, 1, 0, 16'd1, 5);
        step("r_resume", ST_TRACE, 1, 0, 0, 16'd1, 1);
        for (int i = 2; i <= 4; i++) step($sformatf("r_cnt_b%0d", i), ST_TRACE, 1, 0, 0, 16'd1, 32'(i));
        bus.stop_i = 1'b1;
        step("r_stop_vs_rot", ST_DRAIN, 1, 0, 0, 16'd1, 5);
        bus.stop_i = 1'b0;
        bus.commit_valid_i = 2'b00;
        for (int i = 0; i < 3; i++) step($sformatf("r_drain%0d", i), ST_DRAIN, 1, 0, 0, 16'd1, 5);
        step("r_done", ST_DONE, 0, 0, 1, 16'd1, 5);
`else
        bus.rotate_limit_i = 32'd1;
        bus.start_i = 1'b1;
        pq.push_back(16'd0);
        step("n_open", ST_OPEN, 1, 1, 0, 16'd0, 0);
        bus.start_i = 1'b0;
        step("n_trace", ST_TRACE, 1, 0, 0, 16'd0, 0);
        bus.commit_valid_i = 2'b01;
        for (int i = 1; i <= 100; i++) step($sformatf("n_cnt%0d", i), ST_TRACE, 1, 0, 0, 16'd0, 32'(i));
        bus.commit_valid_i = 2'b00;
`endif
        tick();
        tick();
        ending = 1'b1;
        for (int i = 0; i < 5 && !mon_done; i++) tick();
        if (!mon_done) begin
            checks++;
            $display("FAIL monitor_end: got no final monitor pass, want one");
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/cva6v_trace_ctrl.md
CVA6V_TRACE_CTRL -- requirements
Module: cva6v_trace_ctrl

Interface
REQ-001 SHALL have parameter NrCommitPorts, default 2, number of commit ports sampled per cycle.
REQ-002 SHALL have parameter CntW, default 32, width of the retired-instruction counter.
REQ-003 SHALL have parameter DrainCycles, default 4, number of cycles tracing stays enabled after a stop.
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  single-cycle request to open a trace session.
REQ-007 SHALL have port stop_i  input  1  single-cycle request to close the session.
REQ-008 SHALL have port rotate_limit_i  input  CntW  commits per file; 0 means no rotation.
REQ-009 SHALL have port commit_valid_i  input  NrCommitPorts  per-port retire-valid from the RVFI instruction stream.
REQ-010 SHALL have port end_of_test_i  input  32  tracer end-of-test word; nonzero means test finished.
REQ-011 SHALL have port enable_o  output  1  tracer enable.
REQ-012 SHALL have port new_file_o  output  1  one-cycle pulse telling the tracer to open a new file.
REQ-013 SHALL have port file_idx_o  output  16  index of the current trace file.
REQ-014 SHALL have port instr_cnt_o  output  CntW  commits counted in the current file.
REQ-015 SHALL have port state_o  output  3  encoded FSM state, for debug.
REQ-016 SHALL have port done_o  output  1  high while a finished session has not been restarted.

Function
REQ-017 SHALL implement the FSM states IDLE, OPEN, TRACE, ROTATE, DRAIN and DONE.
REQ-018 SHALL move from IDLE or DONE to OPEN on start_i when stop_i is low; start_i together with stop_i in IDLE or DONE SHALL be ignored.
REQ-019 SHALL, in OPEN, assert new_file_o and enable_o for exactly one cycle, clear instr_cnt_o, and then go to TRACE.
REQ-020 SHALL, in TRACE, keep enable_o at 1 and add popcount(commit_valid_i) to instr_cnt_o each cycle, saturating at 2^CntW-1.
REQ-021 SHALL go from TRACE to ROTATE when rotate_limit_i is nonzero and instr_cnt_o plus the current increment is at least rotate_limit_i.
REQ-022 SHALL, in ROTATE, last one cycle: pulse new_file_o, increment file_idx_o (wrapping 0xFFFF to 0), and load instr_cnt_o with that cycle's popcount; the FSM then returns to TRACE.
REQ-023 SHALL go from TRACE, OPEN or ROTATE to DRAIN on stop_i or on a nonzero end_of_test_i; stop SHALL take priority over rotation in the same cycle.
REQ-024 SHALL, in DRAIN, keep enable_o at 1 and keep counting commits for DrainCycles cycles, then go to DONE.
REQ-025 SHALL, in DONE, drive enable_o to 0 and done_o to 1, and hold instr_cnt_o and file_idx_o.
REQ-026 SHALL increment file_idx_o on every new_file_o pulse, including the one in OPEN.
REQ-027 SHALL ignore start_i in OPEN, TRACE, ROTATE and DRAIN, and ignore stop_i in IDLE, DRAIN and DONE.
REQ-028 SHALL never assert new_file_o in two consecutive cycles.

Reset
REQ-029 SHALL, while rst_i is high, put the FSM in IDLE and drive enable_o, new_file_o and done_o to 0, file_idx_o to 0xFFFF (so the first file is 0), and instr_cnt_o to 0.
REQ-030 SHALL, on reset asserted mid-session, abandon the session with no drain and no new_file_o pulse.

Configuration
REQ-031 SHALL, with macro CVA6V_TRACE_CTRL_ROTATE_EN defined, provide the ROTATE state and the behaviour of REQ-021 and REQ-022.
REQ-032 SHALL, without CVA6V_TRACE_CTRL_ROTATE_EN, never enter ROTATE, ignore rotate_limit_i, and change file_idx_o only in OPEN.

Structure
REQ-033 SHALL take the state enum, its 3-bit encoding and the default CntW from the shared package cva6v_trace_ctrl_pkg.
REQ-034 SHALL use the sub-module cva6v_trace_commit_cnt for the popcount and saturating counter (with load and clear); the FSM SHALL stay in the top module.

Verification
REQ-035 SHALL cover: reset, then start_i with limit 0 and 10 cycles of commit_valid_i=2'b11 -> new_file_o pulses once, file_idx_o=0, instr_cnt_o=20.
REQ-036 SHALL cover: limit 5 with commit_valid_i=2'b01 every cycle -> ROTATE after the 5th commit, file_idx_o=1, new_file_o pulsed, counting resumes from 1.
REQ-037 SHALL cover: stop_i and the rotation threshold in the same cycle -> DRAIN, no pulse, and DONE after 4 cycles with enable_o=0 and done_o=1.
REQ-038 SHALL cover: end_of_test_i=32'h1 during TRACE -> DRAIN; 3 commits during drain are added to instr_cnt_o.
REQ-039 SHALL cover: rst_i asserted in TRACE with instr_cnt_o=7 -> next cycle IDLE, enable_o=0, file_idx_o=0xFFFF, instr_cnt_o=0.
REQ-040 SHALL cover: a build without CVA6V_TRACE_CTRL_ROTATE_EN and limit 1 -> no rotation; file_idx_o stays 0 for 100 commits.
